// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex frame decoder.
//   - ASCII constants for the characters with special meaning (CR, LF, SPACE)
//   - Decoder state encoding
//   - err_code values reported on frame_err
package uart_pkg;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ECHO   = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHAR = 2'b01;
  localparam logic [1:0] ERR_ODD  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/uart_hex_frame_decoder_if.sv
// Bundles every non-clock/reset signal of the hex frame decoder.
//   UART side : rx_empty, r_data (FWFT head), rd_uart pop strobe,
//               tx_full, w_data, wr_uart push strobe
//   App side  : byte_out/byte_valid, frame_done/frame_len,
//               frame_err/err_code
// modport master is the decoder's view; modport slave is the view of the
// logic surrounding it (uart_unit FIFOs plus the application).
interface uart_hex_frame_decoder_if #(
  parameter int LEN_W = 5
);

  logic             rx_empty;
  logic [7:0]       r_data;
  logic             rd_uart;
  logic             tx_full;
  logic [7:0]       w_data;
  logic             wr_uart;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             frame_err;
  logic [1:0]       err_code;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart,
    output byte_out, byte_valid, frame_done, frame_len, frame_err, err_code
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart,
    input  byte_out, byte_valid, frame_done, frame_len, frame_err, err_code
  );

endinterface

// File: rtl/ascii_hex_classify.sv
// Combinational classifier for one ASCII character.
//   ch       : character under test
//   is_hex   : 0-9, A-F or a-f
//   nibble   : value of the hex digit (0 when not a hex digit)
//   is_term  : CR or LF
//   is_space : 0x20
import uart_pkg::*;

module ascii_hex_classify (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_term,
  output logic       is_space
);

  // Letters A-F and a-f both carry 1..6 in their low nibble, so adding 9
  // gives 10..15 without caring about case.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
  end

  assign is_term  = (ch == CR) || (ch == LF);
  assign is_space = (ch == SPACE);

endmodule

// File: rtl/uart_hex_frame_decoder.sv
// ASCII hex frame decoder sitting behind uart_unit's receive FIFO.
// Pops one character at a time, optionally echoes it to the TX FIFO,
// turns pairs of hex digits into bytes and reports per-line results.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (master) : see uart_hex_frame_decoder_if
// Parameters:
//   ECHO_EN : 1 = echo each popped character, 0 = no TX activity
//   MAX_LEN : maximum decoded bytes per frame
//   LEN_W   : width of frame_len and the length counter (2^LEN_W > MAX_LEN)
import uart_pkg::*;

module uart_hex_frame_decoder #(
  parameter int ECHO_EN = 1,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  uart_hex_frame_decoder_if.master bus
);

  state_t           state_q, state_d;
  logic [7:0]       ch_q, ch_d;
  logic             rd_q, rd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic [7:0]       byte_q, byte_d;
  logic             bv_q, bv_d;
  logic             fd_q, fd_d;
  logic             fe_q, fe_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic [1:0]       ecode_q, ecode_d;
  logic [3:0]       hi_q, hi_d;
  logic             phase_q, phase_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_line_q, err_line_d;

  logic             is_hex;
  logic [3:0]       nibble;
  logic             is_term;
  logic             is_space;

  ascii_hex_classify u_classify (
    .ch       (ch_q),
    .is_hex   (is_hex),
    .nibble   (nibble),
    .is_term  (is_term),
    .is_space (is_space)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT;
      ch_q       <= 8'h00;
      rd_q       <= 1'b0;
      wdata_q    <= 8'h00;
      wr_q       <= 1'b0;
      byte_q     <= 8'h00;
      bv_q       <= 1'b0;
      fd_q       <= 1'b0;
      fe_q       <= 1'b0;
      flen_q     <= '0;
      ecode_q    <= ERR_NONE;
      hi_q       <= 4'd0;
      phase_q    <= 1'b0;
      len_q      <= '0;
      err_line_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      bv_q       <= bv_d;
      fd_q       <= fd_d;
      fe_q       <= fe_d;
      flen_q     <= flen_d;
      ecode_q    <= ecode_d;
      hi_q       <= hi_d;
      phase_q    <= phase_d;
      len_q      <= len_d;
      err_line_q <= err_line_d;
    end
  end

  // The character is captured from the FWFT head in S_WAIT; the registered
  // pop strobe then releases it one cycle later, so the FIFO head has
  // advanced by the time S_WAIT looks at rx_empty again.
  // Once err_line is set, nothing but a terminator can change line state,
  // which is what makes the first error of a line the one reported.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rd_d       = 1'b0;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    byte_d     = byte_q;
    bv_d       = 1'b0;
    fd_d       = 1'b0;
    fe_d       = 1'b0;
    flen_d     = flen_q;
    ecode_d    = ecode_q;
    hi_d       = hi_q;
    phase_d    = phase_q;
    len_d      = len_q;
    err_line_d = err_line_q;

    case (state_q)
      S_WAIT: begin
        if (!bus.rx_empty) begin
          ch_d    = bus.r_data;
          rd_d    = 1'b1;
          state_d = (ECHO_EN != 0) ? S_ECHO : S_DECODE;
        end
      end

      S_ECHO: begin
        if (!bus.tx_full) begin
          wr_d    = 1'b1;
          wdata_d = ch_q;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_WAIT;
        if (is_term) begin
          if (err_line_q) begin
            fe_d = 1'b1;
          end else if (phase_q) begin
            fe_d    = 1'b1;
            ecode_d = ERR_ODD;
          end else if (len_q != '0) begin
            fd_d   = 1'b1;
            flen_d = len_q;
          end
          len_d      = '0;
          phase_d    = 1'b0;
          err_line_d = 1'b0;
        end else if (!err_line_q) begin
          if (is_hex) begin
            if (!phase_q) begin
              hi_d    = nibble;
              phase_d = 1'b1;
            end else if (len_q == LEN_W'(MAX_LEN)) begin
              err_line_d = 1'b1;
              ecode_d    = ERR_OVF;
            end else begin
              byte_d  = {hi_q, nibble};
              bv_d    = 1'b1;
              len_d   = len_q + LEN_W'(1);
              phase_d = 1'b0;
            end
          end else if (!is_space) begin
            err_line_d = 1'b1;
            ecode_d    = ERR_CHAR;
          end
        end
      end

      default: state_d = S_WAIT;
    endcase
  end

  assign bus.rd_uart    = rd_q;
  assign bus.w_data     = wdata_q;
  assign bus.wr_uart    = wr_q;
  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = bv_q;
  assign bus.frame_done = fd_q;
  assign bus.frame_len  = flen_q;
  assign bus.frame_err  = fe_q;
  assign bus.err_code   = ecode_q;

endmodule

// File: tb/tb_uart_hex_frame_decoder.sv
// Testbench for uart_hex_frame_decoder.
// Two instances run side by side on the same character stream:
//   dut_a : ECHO_EN=1, MAX_LEN=16, LEN_W=5
//   dut_b : ECHO_EN=0, MAX_LEN=4,  LEN_W=3
// In bench strings '~' stands for CR and '|' for LF.
import uart_pkg::*;

module tb_uart_hex_frame_decoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_hex_frame_decoder_if #(.LEN_W(5)) bus_a ();
  uart_hex_frame_decoder_if #(.LEN_W(3)) bus_b ();

  uart_hex_frame_decoder #(.ECHO_EN(1), .MAX_LEN(16), .LEN_W(5)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  uart_hex_frame_decoder #(.ECHO_EN(0), .MAX_LEN(4), .LEN_W(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // RX FIFO models: main process appends at wi_*, FIFO process consumes ri_*
  logic [7:0] stream_a [0:8191];
  logic [7:0] stream_b [0:8191];
  int wi_a = 0, wi_b = 0;
  int ri_a = 0, ri_b = 0;

  always @(posedge clk) begin
    if (bus_a.rd_uart && ri_a < wi_a) ri_a = ri_a + 1;
    bus_a.rx_empty <= (ri_a >= wi_a);
    bus_a.r_data   <= stream_a[ri_a];
  end

  always @(posedge clk) begin
    if (bus_b.rd_uart && ri_b < wi_b) ri_b = ri_b + 1;
    bus_b.rx_empty <= (ri_b >= wi_b);
    bus_b.r_data   <= stream_b[ri_b];
  end

  // Observed activity, recorded away from the active edge
  int         act_a[$];
  int         act_b[$];
  logic [7:0] echo_a[$];
  int         rd_a_count = 0;
  int         wr_b_count = 0;
  int         excl_a = 0;
  int         excl_b = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_a.byte_valid) act_a.push_back(32'h100 | int'(bus_a.byte_out));
      if (bus_a.frame_done) act_a.push_back(32'h200 | int'(bus_a.frame_len));
      if (bus_a.frame_err)  act_a.push_back(32'h300 | int'(bus_a.err_code));
      if (bus_b.byte_valid) act_b.push_back(32'h100 | int'(bus_b.byte_out));
      if (bus_b.frame_done) act_b.push_back(32'h200 | int'(bus_b.frame_len));
      if (bus_b.frame_err)  act_b.push_back(32'h300 | int'(bus_b.err_code));
      if (bus_a.wr_uart) echo_a.push_back(bus_a.w_data);
      if (bus_a.rd_uart) rd_a_count++;
      if (bus_b.wr_uart) wr_b_count++;
      if (int'(bus_a.byte_valid) + int'(bus_a.frame_done) + int'(bus_a.frame_err) > 1) excl_a++;
      if (int'(bus_b.byte_valid) + int'(bus_b.frame_done) + int'(bus_b.frame_err) > 1) excl_b++;
    end
  end

  // Reference model state: expected events, echoes and the line in progress
  int         exp_a[$];
  int         exp_b[$];
  logic [7:0] exp_echo_a[$];
  logic [7:0] line_a[$];
  logic [7:0] line_b[$];
  int         rp_a = 0, rp_b = 0, rp_echo = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] xlate(input logic [7:0] c);
    if (c == "~") return 8'h0D;
    if (c == "|") return 8'h0A;
    return c;
  endfunction

  // Whole-line evaluation: digits pair into bytes left to right; the first
  // offending character (illegal or one pair too many) decides the error.
  task automatic model_line(input int which);
    logic [7:0] ln[$];
    int evs[$];
    int max_len, nd, err, hi, v;
    if (which == 0) begin ln = line_a; line_a.delete(); max_len = 16; end
    else begin ln = line_b; line_b.delete(); max_len = 4; end
    nd = 0; err = 0; hi = 0;
    for (int i = 0; i < ln.size(); i++) begin
      if (ln[i] == 8'h20) continue;
      v = hex_val(ln[i]);
      if (v < 0) begin err = 1; break; end
      if (nd % 2 == 0) hi = v;
      else begin
        if (nd / 2 >= max_len) begin err = 3; break; end
        evs.push_back(32'h100 | (hi * 16 + v));
      end
      nd++;
    end
    if (err != 0)         evs.push_back(32'h300 | err);
    else if (nd % 2 == 1) evs.push_back(32'h302);
    else if (nd > 0)      evs.push_back(32'h200 | (nd / 2));
    foreach (evs[i]) begin
      if (which == 0) exp_a.push_back(evs[i]);
      else            exp_b.push_back(evs[i]);
    end
  endtask

  task automatic applyStimulus(input int mask, input logic [7:0] raw);
    logic [7:0] c;
    c = xlate(raw);
    if ((mask & 1) != 0) begin
      stream_a[wi_a] = c;
      wi_a++;
      exp_echo_a.push_back(c);
      if (c == 8'h0D || c == 8'h0A) model_line(0);
      else line_a.push_back(c);
    end
    if ((mask & 2) != 0) begin
      stream_b[wi_b] = c;
      wi_b++;
      if (c == 8'h0D || c == 8'h0A) model_line(1);
      else line_b.push_back(c);
    end
  endtask

  task automatic feed(input int mask, input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      applyStimulus(mask, c);
    end
  endtask

  task automatic drain(input bit rnd_tx);
    int guard;
    guard = 0;
    while ((ri_a < wi_a || ri_b < wi_b) && guard < 20000) begin
      @(negedge clk);
      if (rnd_tx) bus_a.tx_full = ($urandom_range(0, 2) == 0);
      guard++;
    end
    bus_a.tx_full = 1'b0;
    repeat (10) @(negedge clk);
    if (guard >= 20000) checkOutput("drain_timeout", guard, 0);
  endtask

  task automatic checkQueues(input string tag);
    int n;
    n = act_a.size() - rp_a;
    checkOutput({tag, "_evA_count"}, n, exp_a.size());
    for (int i = 0; i < n && i < exp_a.size(); i++)
      checkOutput({tag, "_evA"}, act_a[rp_a + i], exp_a[i]);
    rp_a = act_a.size();
    exp_a.delete();

    n = act_b.size() - rp_b;
    checkOutput({tag, "_evB_count"}, n, exp_b.size());
    for (int i = 0; i < n && i < exp_b.size(); i++)
      checkOutput({tag, "_evB"}, act_b[rp_b + i], exp_b[i]);
    rp_b = act_b.size();
    exp_b.delete();

    n = echo_a.size() - rp_echo;
    checkOutput({tag, "_echo_count"}, n, exp_echo_a.size());
    for (int i = 0; i < n && i < exp_echo_a.size(); i++)
      checkOutput({tag, "_echo"}, echo_a[rp_echo + i], exp_echo_a[i]);
    rp_echo = echo_a.size();
    exp_echo_a.delete();

    checkOutput({tag, "_wrB"}, wr_b_count, 0);
    checkOutput({tag, "_exclA"}, excl_a, 0);
    checkOutput({tag, "_exclB"}, excl_b, 0);
  endtask

  initial begin
    string hex_tbl;
    string bad_tbl;
    int rd0, r, n;
    logic [7:0] c;
    hex_tbl = "0123456789ABCDEFabcdef";
    bad_tbl = "GgZz.:-#";

    bus_a.tx_full = 1'b0;
    bus_b.tx_full = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_rd",    bus_a.rd_uart,    0);
    checkOutput("rst_wr",    bus_a.wr_uart,    0);
    checkOutput("rst_byte",  bus_a.byte_out,   0);
    checkOutput("rst_bv",    bus_a.byte_valid, 0);
    checkOutput("rst_fd",    bus_a.frame_done, 0);
    checkOutput("rst_len",   bus_a.frame_len,  0);
    checkOutput("rst_fe",    bus_a.frame_err,  0);
    checkOutput("rst_code",  bus_a.err_code,   0);
    checkOutput("rst_wdata", bus_a.w_data,     0);
    checkOutput("rst_len_b", bus_b.frame_len,  0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed frames");
    feed(3, "3A~");
    drain(1'b0);
    checkQueues("t_3A");
    checkOutput("t_3A_byte", bus_a.byte_out, 8'h3A);
    checkOutput("t_3A_len",  bus_a.frame_len, 1);

    feed(3, "a5 0F~|");
    drain(1'b0);
    checkQueues("t_a50F");
    checkOutput("t_a50F_len", bus_a.frame_len, 2);

    feed(3, "3G7~");
    drain(1'b0);
    checkQueues("t_3G7");
    checkOutput("t_3G7_code", bus_a.err_code, 2'b01);
    feed(3, "11~");
    drain(1'b0);
    checkQueues("t_11");
    checkOutput("t_11_len", bus_a.frame_len, 1);

    feed(3, "ABC~");
    drain(1'b0);
    checkQueues("t_ABC");
    checkOutput("t_ABC_code", bus_a.err_code, 2'b10);

    feed(3, "0102030405~");
    drain(1'b0);
    checkQueues("t_ovf");
    checkOutput("t_ovf_code_b", bus_b.err_code, 2'b11);
    checkOutput("t_ovf_len_a",  bus_a.frame_len, 5);

    $display("[TB] echo stall");
    bus_a.tx_full = 1'b1;
    rd0 = rd_a_count;
    feed(1, "5~");
    repeat (20) @(negedge clk);
    checkOutput("stall_rd", rd_a_count - rd0, 1);
    checkOutput("stall_wr", echo_a.size() - rp_echo, 0);
    bus_a.tx_full = 1'b0;
    drain(1'b0);
    checkQueues("stall");

    $display("[TB] reset mid-frame");
    feed(3, "1");
    drain(1'b0);
    reset_n = 1'b0;
    line_a.delete();
    line_b.delete();
    repeat (2) @(negedge clk);
    checkOutput("midrst_byte", bus_a.byte_out, 0);
    checkOutput("midrst_code", bus_b.err_code, 0);
    reset_n = 1'b1;
    @(negedge clk);
    feed(3, "22~");
    drain(1'b0);
    checkQueues("midrst");
    checkOutput("midrst_byte22", bus_a.byte_out, 8'h22);
    checkOutput("midrst_len",    bus_a.frame_len, 1);

    $display("[TB] random frames");
    for (int batch = 0; batch < 8; batch++) begin
      for (int ln = 0; ln < 5; ln++) begin
        n = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 45) : $urandom_range(0, 12);
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(0, 99);
          if (r < 80)      c = hex_tbl[$urandom_range(0, 21)];
          else if (r < 97) c = 8'h20;
          else             c = bad_tbl[$urandom_range(0, 7)];
          applyStimulus(3, c);
        end
        r = $urandom_range(0, 2);
        if (r == 0)      applyStimulus(3, "~");
        else if (r == 1) applyStimulus(3, "|");
        else begin
          applyStimulus(3, "~");
          applyStimulus(3, "|");
        end
      end
      drain(1'b1);
      checkQueues("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_hex_frame_decoder.md
Name: uart_hex_frame_decoder

Overview:
- Sits directly downstream of uart_unit's receive side.
- Pops ASCII characters from the RX FIFO and optionally echoes each one into the TX FIFO.
- Converts pairs of ASCII hex digits into bytes; CR or LF terminates a frame.
- Presents decoded bytes, a per-frame completion strobe with length, and error strobes to the application logic that replaces the button-driven loopback demo.

Parameters:
- ECHO_EN, 1: 1 = write every popped character back to the TX FIFO; 0 = no TX activity.
- MAX_LEN, 16: maximum decoded bytes per frame.
- LEN_W, 5: width of frame_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_empty  input  1  RX FIFO empty flag from uart_unit
- r_data  input  8  RX FIFO head data, first-word fall-through, valid while rx_empty=0
- rd_uart  output  1  one-cycle pop strobe to the RX FIFO
- tx_full  input  1  TX FIFO full flag from uart_unit
- w_data  output  8  echo character to the TX FIFO
- wr_uart  output  1  one-cycle push strobe to the TX FIFO
- byte_out  output  8  last decoded byte, held until the next decoded byte
- byte_valid  output  1  one-cycle strobe, byte_out new
- frame_done  output  1  one-cycle strobe, good frame terminated
- frame_len  output  LEN_W  bytes in the last good frame, held
- frame_err  output  1  one-cycle strobe, bad frame terminated
- err_code  output  2  01 illegal char, 10 odd digit count, 11 overflow; held

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset:
  - state = S_WAIT.
  - All strobes, byte_out, frame_len, err_code, nibble and length counters and err_line = 0.
- All outputs are registered.
- S_WAIT:
  - If rx_empty=0: capture r_data into ch_reg and assert rd_uart for exactly one cycle.
  - Next state is S_ECHO if ECHO_EN, else S_DECODE.
  - While rx_empty=1: remain in S_WAIT with rd_uart=0.
- S_ECHO:
  - If tx_full=0: wr_uart=1 for one cycle, w_data=ch_reg, go to S_DECODE.
  - If tx_full=1: stall with wr_uart=0 and no further pops.
- S_DECODE (one cycle, always returns to S_WAIT). Character classes:
  - Hex digit (0-9, A-F, a-f), with err_line=0:
    - nibble_phase=0: store the high nibble; set phase=1.
    - nibble_phase=1: byte_out={hi,lo}, byte_valid=1, len+1, phase=0.
    - If len==MAX_LEN before the increment: no byte_valid, set err_line, err_code=11.
  - Space (0x20): ignored.
  - Any other character except CR/LF: set err_line, err_code=01 (first error wins), no byte_valid.
  - Characters arriving while err_line=1 are discarded until a terminator.
  - CR (0x0D) or LF (0x0A):
    - If err_line: frame_err=1.
    - Else if phase=1: frame_err=1, err_code=10.
    - Else if len>0: frame_done=1, frame_len=len.
    - Else (empty line, e.g. the LF of a CRLF pair): no strobe.
    - In all cases clear len, phase and err_line.
- Timing, no stall:
  - Pop in cycle N, echo in N+1, decode in N+2.
  - Strobes are visible in N+3 with ECHO_EN=1, N+2 with ECHO_EN=0.
  - Maximum throughput is one character per 3 cycles (2 with ECHO_EN=0).
- At most one of byte_valid, frame_done, frame_err is high in any cycle.
- Length counter width is LEN_W. It never wraps; saturation is reported as overflow.
- Reset mid-frame discards partial state. A character popped but not yet echoed is lost; this is accepted.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants: CR, LF, SPACE.
  - State encoding: S_WAIT, S_ECHO, S_DECODE.
  - err_code localparams: ERR_CHAR, ERR_ODD, ERR_OVF.
- Sub-module ascii_hex_classify (combinational):
  - Inputs: 8-bit character.
  - Outputs: is_hex, nibble[3:0], is_term, is_space.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- "3A\r" with ECHO_EN=1, tx_full=0:
  - wr_uart pushes 0x33, 0x41, 0x0D.
  - byte_valid once with byte_out=0x3A.
  - frame_done with frame_len=1.
- "a5 0F\r\n":
  - byte_valid 0xA5 then 0x0F.
  - frame_done with frame_len=2.
  - No strobe for the trailing LF.
- "3G7\r":
  - No byte_valid.
  - frame_err with err_code=01.
  - Next frame "11\r" decodes 0x11 with frame_done and frame_len=1.
- "ABC\r":
  - byte_valid 0xAB.
  - frame_err with err_code=10.
- MAX_LEN=4, "0102030405\r":
  - Four byte_valid strobes (01..04).
  - frame_err with err_code=11.
- Stall and reset:
  - tx_full held high for 20 cycles after the first pop: exactly one rd_uart, no wr_uart, then echo on release.
  - reset_n pulsed low mid-frame after "1": then "22\r" yields byte 0x22 and frame_len=1.
